tree_fanout_bp: RTL and testbench
=================================

# tree_fanout_bp

Parametrised, backpressure-aware broadcast tree that replicates one `in_w`-bit beat onto `fanout_factor` output lanes. It uses a generate loop of registered doubling stages. Every stage is a 2-entry skid buffer, so `dn_rdy` is honoured end to end at full throughput. A per-beat lane-enable mask travels with the data and zeroes disabled lanes at the output. The block sits between a stream source and wide consumer arrays (Q/K/V or PE columns) and replaces fixed-depth fanouts that ignore ready.

## Interface
- `in_w`, default 1024: beat width in bits.
- `fanout_factor`, default 3: number of output lanes, legal range 1..256.
- `mask_en`, default 1: 1 carries and applies `lane_en`; 0 ignores `lane_en` and enables all lanes.
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `up_vld`  in  1: upstream beat valid.
- `up_rdy`  out  1: block can accept a beat (registered).
- `up_dat`  in  `in_w`: beat data.
- `lane_en`  in  `fanout_factor`: lane mask, sampled with `up_dat`.
- `dn_vld`  out  1: output beat valid.
- `dn_rdy`  in  1: downstream ready.
- `dn_dat`  out  `fanout_factor*in_w`: lane i occupies bits [i*in_w +: in_w].
- `busy`  out  1: at least one stage holds a beat.

## Operation
- Depth: L = clog2(`fanout_factor`), computed by a package function; L = 0 when `fanout_factor` = 1.
- Stage 0 is a plain (non-doubling) skid stage that captures the input. Stages 1..L each double the width: stage k holds `in_w`·2^k data bits plus `fanout_factor` mask bits.
- Output comes from stage L. Data is truncated to the low `fanout_factor*in_w` bits, and lane i is forced to 0 when `mask_en` = 1 and `lane_en[i]` = 0.
- Each stage:
  - Has a main register and a skid register.
  - Its input ready equals "skid empty", registered.
  - A transfer occurs when vld and rdy are both high.
  - If the downstream stage stalls while a beat arrives, the beat goes to the skid register.
  - When the downstream stage drains, the skid register refills the main register before any new input is taken.
  - Beat order is strictly preserved.
- Total capacity is 2·(L+1) beats. `up_rdy` falls only when stage 0's skid register is full.
- Stages share no combinational ready path. The `dn_rdy` to `up_rdy` path is registered per stage.
- `busy` is the OR of all main and skid valid bits.

## Timing
- Reset values: `dn_vld` = 0, `dn_dat` = 0, `busy` = 0, `up_rdy` = 1. All stage registers are cleared.
- Latency: a beat accepted at cycle t appears on `dn_vld` at cycle t+L+1 when `dn_rdy` is held high. Examples: `fanout_factor` = 3 gives 3 cycles; `fanout_factor` = 1 gives 1 cycle.
- Throughput is 1 beat per cycle with `dn_rdy` held high, sustained indefinitely.
- `dn_vld` and `dn_dat` stay stable while `dn_vld`=1 and `dn_rdy`=0.
- `dn_rdy` may toggle on every cycle. No beat is lost or duplicated.
- `up_vld` high while `up_rdy`=0 is legal. The beat is not taken and the source must hold it.
- `dn_rdy` rising in the same cycle `up_rdy` is low: `up_rdy` rises no earlier than 1 cycle later.
- Asserting `rst_n` low at any time discards all in-flight beats. Outputs return to their reset values asynchronously.
- Widths: `lane_en` bits ≥ `fanout_factor` are ignored. Non-power-of-two fanouts discard the unused upper replicas.

## Structure
- `tree_fanout_pkg` holds `FANOUT_MAX` = 256 and the function `fanout_levels(f)`, which returns clog2(f) and returns 0 for f = 1.
- Sub-module `tree_fanout_skid_stage` holds one skid stage, with parameters `in_w`, `out_w` (= `in_w` or 2·`in_w`) and `side_w` (mask). It is instantiated L+1 times in a generate loop.
- The top level contains only the generate chain, the truncation and mask logic, and `busy`.

## Test plan
- `fanout_factor`=3, `in_w`=8, `dn_rdy`=1: send beats 0x01..0x10 back-to-back. Required: `dn_dat` = {x,x,x} for each beat, first beat out at cycle 3, 16 consecutive `dn_vld` cycles.
- `fanout_factor`=4: hold `dn_rdy`=0 and `up_vld`=1. Required: exactly 6 beats accepted, then `up_rdy`=0. Release `dn_rdy`: all 6 beats emerge in order with no gaps.
- Drive `dn_rdy` with a random 50% pattern over 1000 beats against a scoreboard. Required: zero loss, zero duplication, order preserved, output stable during stalls.
- `fanout_factor`=5, `up_dat`=0xA5, `lane_en`=5'b10110. Required: lanes 0 and 3 = 0x00, lanes 1, 2 and 4 = 0xA5. With `mask_en`=0: all lanes = 0xA5.
- `fanout_factor`=1 and `fanout_factor`=256: check 1-cycle and 9-cycle latency respectively, and full throughput in both.
- Pulse `rst_n` low mid-stream with 4 beats in flight. Required: `dn_vld`=0, `busy`=0 and `up_rdy`=1 immediately, and none of the old beats appear after reset.

Source files
------------

// File: rtl/tree_fanout_pkg.sv
// tree_fanout_pkg: shared constants and depth helper for the broadcast tree.
package tree_fanout_pkg;
  localparam int FANOUT_MAX = 256;
  function automatic int fanout_levels(input int f);
    int l;
    l = 0;
    while ((1 << l) < f) l++;
    return l;
  endfunction
endpackage

// File: rtl/tree_fanout_skid_stage.sv
// tree_fanout_skid_stage: 2-entry skid stage that optionally doubles its beat by replication.
module tree_fanout_skid_stage #(
  parameter int in_w = 8,
  parameter int out_w = 8,
  parameter int side_w = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [in_w-1:0]   in_dat,
  input  logic [side_w-1:0] in_side,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [out_w-1:0]  out_dat,
  output logic [side_w-1:0] out_side,
  output logic              busy
);
  logic              skid_vld;
  logic [in_w-1:0]   skid_dat;
  logic [side_w-1:0] skid_side;
  logic              take, pop;
  assign in_rdy = !skid_vld;
  assign take = in_vld && !skid_vld;
  assign pop = out_vld && out_rdy;
  assign busy = out_vld || skid_vld;
  // The skid is only ever loaded when main is full and stalled; it always drains into main first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_side <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
      skid_side <= '0;
    end else if (skid_vld) begin
      if (pop) begin
        out_dat <= {(out_w/in_w){skid_dat}};
        out_side <= skid_side;
        skid_vld <= 1'b0;
      end
    end else if (take) begin
      if (!out_vld || pop) begin
        out_vld <= 1'b1;
        out_dat <= {(out_w/in_w){in_dat}};
        out_side <= in_side;
      end else begin
        skid_vld <= 1'b1;
        skid_dat <= in_dat;
        skid_side <= in_side;
      end
    end else if (pop) begin
      out_vld <= 1'b0;
    end
  end
endmodule

// File: rtl/tree_fanout_bp.sv
// tree_fanout_bp: ready-aware broadcast tree replicating one beat onto fanout_factor masked lanes.
module tree_fanout_bp
  import tree_fanout_pkg::*;
#(
  parameter int in_w = 1024,
  parameter int fanout_factor = 3,
  parameter int mask_en = 1
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up_vld,
  output logic                          up_rdy,
  input  logic [in_w-1:0]               up_dat,
  input  logic [fanout_factor-1:0]      lane_en,
  output logic                          dn_vld,
  input  logic                          dn_rdy,
  output logic [fanout_factor*in_w-1:0] dn_dat,
  output logic                          busy
);
  localparam int L = fanout_levels(fanout_factor);
  localparam int OFS = in_w * ((1 << L) - 1);
  // Stage k's data lives at chain[in_w*(2^k-1) +: in_w*2^k].
  logic [in_w*((2 << L) - 1)-1:0] chain;
  logic [L:0]                     vld, occ;
  logic [L+1:0]                   rdy;
  logic [fanout_factor-1:0]       side [L+1];
  assign up_rdy = rdy[0];
  assign rdy[L+1] = dn_rdy;
  assign dn_vld = vld[L];
  assign busy = |occ;
  for (genvar k = 0; k <= L; k++) begin : stg
    localparam int IW = k == 0 ? in_w : in_w << (k - 1);
    logic                     in_vld;
    logic [IW-1:0]            in_dat;
    logic [fanout_factor-1:0] in_side;
    if (k == 0) begin : g_src
      assign in_vld = up_vld;
      assign in_dat = up_dat;
      assign in_side = mask_en != 0 ? lane_en : '1;
    end else begin : g_src
      assign in_vld = vld[k-1];
      assign in_dat = chain[in_w*((1 << (k-1)) - 1) +: IW];
      assign in_side = side[k-1];
    end
    tree_fanout_skid_stage #(.in_w(IW), .out_w(in_w << k), .side_w(fanout_factor)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .in_vld(in_vld),
      .in_rdy(rdy[k]),
      .in_dat(in_dat),
      .in_side(in_side),
      .out_vld(vld[k]),
      .out_rdy(rdy[k+1]),
      .out_dat(chain[in_w*((1 << k) - 1) +: (in_w << k)]),
      .out_side(side[k]),
      .busy(occ[k])
    );
  end
  for (genvar i = 0; i < fanout_factor; i++) begin : lane
    assign dn_dat[i*in_w +: in_w] = side[L][i] ? chain[OFS + i*in_w +: in_w] : '0;
  end
endmodule

// File: tb/tb_tree_fanout_bp.sv
// tb_tree_fanout_bp: randomized scoreboard bench over several fanout configurations of tree_fanout_bp.
module tb_tree_fanout_bp;
  localparam int N = 6;
  localparam int FF [N] = '{3, 4, 5, 5, 1, 256};
  localparam bit MEN [N] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] up_vld, up_rdy, dn_vld, dn_rdy, busy;
  logic [7:0] up_dat [N];
  logic [255:0] lane_en [N];
  logic [23:0] d0;
  logic [31:0] d1;
  logic [39:0] d2, d3;
  logic [7:0] d4;
  logic [2047:0] d5;
  logic [2047:0] dz [N];
  logic [263:0] sb [N][4096];
  int wp [N], rp [N];
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign dz[0] = 2048'(d0);
  assign dz[1] = 2048'(d1);
  assign dz[2] = 2048'(d2);
  assign dz[3] = 2048'(d3);
  assign dz[4] = 2048'(d4);
  assign dz[5] = d5;

  tree_fanout_bp #(.in_w(8), .fanout_factor(3), .mask_en(1)) u0 (.clk(clk), .rst_n(rst_n),
    .up_vld(up_vld[0]), .up_rdy(up_rdy[0]), .up_dat(up_dat[0]), .lane_en(lane_en[0][2:0]),
    .dn_vld(dn_vld[0]), .dn_rdy(dn_rdy[0]), .dn_dat(d0), .busy(busy[0]));
  tree_fanout_bp #(.in_w(8), .fanout_factor(4), .mask_en(1)) u1 (.clk(clk), .rst_n(rst_n),
    .up_vld(up_vld[1]), .up_rdy(up_rdy[1]), .up_dat(up_dat[1]), .lane_en(lane_en[1][3:0]),
    .dn_vld(dn_vld[1]), .dn_rdy(dn_rdy[1]), .dn_dat(d1), .busy(busy[1]));
  tree_fanout_bp #(.in_w(8), .fanout_factor(5), .mask_en(1)) u2 (.clk(clk), .rst_n(rst_n),
    .up_vld(up_vld[2]), .up_rdy(up_rdy[2]), .up_dat(up_dat[2]), .lane_en(lane_en[2][4:0]),
    .dn_vld(dn_vld[2]), .dn_rdy(dn_rdy[2]), .dn_dat(d2), .busy(busy[2]));
  tree_fanout_bp #(.in_w(8), .fanout_factor(5), .mask_en(0)) u3 (.clk(clk), .rst_n(rst_n),
    .up_vld(up_vld[3]), .up_rdy(up_rdy[3]), .up_dat(up_dat[3]), .lane_en(lane_en[3][4:0]),
    .dn_vld(dn_vld[3]), .dn_rdy(dn_rdy[3]), .dn_dat(d3), .busy(busy[3]));
  tree_fanout_bp #(.in_w(8), .fanout_factor(1), .mask_en(1)) u4 (.clk(clk), .rst_n(rst_n),
    .up_vld(up_vld[4]), .up_rdy(up_rdy[4]), .up_dat(up_dat[4]), .lane_en(lane_en[4][0:0]),
    .dn_vld(dn_vld[4]), .dn_rdy(dn_rdy[4]), .dn_dat(d4), .busy(busy[4]));
  tree_fanout_bp #(.in_w(8), .fanout_factor(256), .mask_en(1)) u5 (.clk(clk), .rst_n(rst_n),
    .up_vld(up_vld[5]), .up_rdy(up_rdy[5]), .up_dat(up_dat[5]), .lane_en(lane_en[5]),
    .dn_vld(dn_vld[5]), .dn_rdy(dn_rdy[5]), .dn_dat(d5), .busy(busy[5]));

  task automatic chk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (low 96 bits)", nm, act[95:0], exp[95:0]);
    end
  endtask

  // Every enabled lane carries the beat; disabled lanes read zero.
  function automatic logic [2047:0] expv(input int ff, input bit men, input logic [7:0] d, input logic [255:0] m);
    logic [2047:0] r;
    r = '0;
    for (int i = 0; i < ff; i++) r[i*8 +: 8] = (!men || m[i]) ? d : 8'h00;
    return r;
  endfunction

  logic stall [N];
  logic [2047:0] held [N];
  initial begin
    for (int k = 0; k < N; k++) begin wp[k] = 0; rp[k] = 0; stall[k] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!rst_n) begin
          rp[k] = wp[k];
          stall[k] = 1'b0;
        end else begin
          if (stall[k]) begin
            chk($sformatf("stable_vld%0d", k), 2048'(dn_vld[k]), 2048'(1));
            chk($sformatf("stable_dat%0d", k), dz[k], held[k]);
          end
          if (dn_vld[k] && dn_rdy[k]) begin
            if (rp[k] == wp[k]) begin
              n_cmp++;
              n_fail++;
              $display("FAIL spurious%0d: got beat %h want none", k, dz[k][95:0]);
            end else begin
              chk($sformatf("dout%0d", k), dz[k],
                  expv(FF[k], MEN[k], sb[k][rp[k] % 4096][7:0], sb[k][rp[k] % 4096][263:8]));
              rp[k]++;
            end
          end
          if (up_vld[k] && up_rdy[k]) begin
            sb[k][wp[k] % 4096] = {lane_en[k], up_dat[k]};
            wp[k]++;
          end
          stall[k] = dn_vld[k] && !dn_rdy[k];
          held[k] = dz[k];
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic burst(input int k, input int lat_exp);
    lane_en[k] = '1;
    dn_rdy[k] = 1'b1;
    fork
      begin
        for (int j = 0; j < 16; j++) begin
          up_vld[k] = 1'b1;
          up_dat[k] = 8'(j + 1);
          @(posedge clk); #1;
        end
        up_vld[k] = 1'b0;
      end
      begin
        int lat, run;
        lat = 0;
        run = 0;
        @(negedge clk);
        while (!dn_vld[k] && lat < 40) begin @(negedge clk); lat++; end
        chk($sformatf("latency%0d", k), 2048'(lat), 2048'(lat_exp));
        while (dn_vld[k] && run < 40) begin
          if (k == 0) chk("burst_lit", dz[0], 2048'({3{8'(run + 1)}}));
          run++;
          @(negedge clk);
        end
        chk($sformatf("burst_run%0d", k), 2048'(run), 2048'(16));
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic stream(input int k, input int n, input int rpct);
    int sent, guard;
    logic fire;
    sent = 0;
    guard = 0;
    up_vld[k] = 1'b0;
    while (sent < n && guard < 30000) begin
      if (!up_vld[k] && $urandom_range(99) < 70) begin
        up_vld[k] = 1'b1;
        up_dat[k] = 8'($urandom);
        lane_en[k] = {8{$urandom}};
      end
      dn_rdy[k] = $urandom_range(99) < rpct;
      @(negedge clk);
      fire = up_vld[k] && up_rdy[k];
      @(posedge clk); #1;
      guard++;
      if (fire) begin sent++; up_vld[k] = 1'b0; end
    end
    up_vld[k] = 1'b0;
    while (wp[k] != rp[k] && guard < 30000) begin
      dn_rdy[k] = $urandom_range(99) < rpct;
      @(posedge clk); #1;
      guard++;
    end
    chk($sformatf("stream_bound%0d", k), 2048'(guard < 30000), 2048'(1));
    chk($sformatf("stream_sent%0d", k), 2048'(sent), 2048'(n));
    dn_rdy[k] = 1'b1;
  endtask

  initial begin
    int acc, run, w, cnt;
    rst_n = 1'b0;
    up_vld = '0;
    dn_rdy = '1;
    for (int k = 0; k < N; k++) begin up_dat[k] = '0; lane_en[k] = '1; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_vld%0d", k), 2048'(dn_vld[k]), 2048'(0));
      chk($sformatf("rst_busy%0d", k), 2048'(busy[k]), 2048'(0));
      chk($sformatf("rst_rdy%0d", k), 2048'(up_rdy[k]), 2048'(1));
      chk($sformatf("rst_dat%0d", k), dz[k], '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    burst(0, 3);
    burst(4, 1);
    burst(5, 9);

    for (int k = 2; k < 4; k++) begin
      up_vld[k] = 1'b1;
      up_dat[k] = 8'hA5;
      lane_en[k] = 256'b10110;
    end
    @(posedge clk); #1;
    up_vld[2] = 1'b0;
    up_vld[3] = 1'b0;
    w = 0;
    while (!dn_vld[2] && w < 20) begin @(negedge clk); w++; end
    chk("mask_vld", 2048'(dn_vld[2]), 2048'(1));
    chk("mask_on", dz[2], 2048'(40'hA5_00_A5_A5_00));
    chk("mask_off_vld", 2048'(dn_vld[3]), 2048'(1));
    chk("mask_off", dz[3], 2048'(40'hA5_A5_A5_A5_A5));
    @(posedge clk); #1;

    dn_rdy[1] = 1'b0;
    up_vld[1] = 1'b1;
    up_dat[1] = 8'h41;
    lane_en[1] = '1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (up_rdy[1]) acc++;
      @(posedge clk); #1;
      up_dat[1] = 8'(8'h41 + acc);
    end
    up_vld[1] = 1'b0;
    chk("cap_accepted", 2048'(acc), 2048'(6));
    @(negedge clk);
    chk("cap_full_rdy", 2048'(up_rdy[1]), 2048'(0));
    @(posedge clk); #1;
    dn_rdy[1] = 1'b1;
    @(negedge clk);
    chk("rdy_reg_delay", 2048'(up_rdy[1]), 2048'(0));
    run = 0;
    while (dn_vld[1] && run < 20) begin
      chk("cap_order", dz[1], 2048'({4{8'(8'h41 + run)}}));
      run++;
      @(negedge clk);
    end
    chk("cap_drain_run", 2048'(run), 2048'(6));
    @(posedge clk); #1;

    stream(0, 1000, 50);
    for (int k = 1; k < N; k++) stream(k, 150, 50);

    dn_rdy[0] = 1'b0;
    lane_en[0] = '1;
    for (int j = 0; j < 4; j++) begin
      up_vld[0] = 1'b1;
      up_dat[0] = 8'(8'h80 + j);
      @(posedge clk); #1;
    end
    up_vld[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", 2048'(busy[0]), 2048'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 2048'(dn_vld[0]), 2048'(0));
    chk("arst_busy", 2048'(busy[0]), 2048'(0));
    chk("arst_rdy", 2048'(up_rdy[0]), 2048'(1));
    chk("arst_dat", dz[0], '0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn_rdy[0] = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (dn_vld[0]) cnt++;
    end
    chk("no_old_beats", 2048'(cnt), 2048'(0));
    for (int k = 0; k < N; k++) chk($sformatf("idle_busy%0d", k), 2048'(busy[k]), 2048'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
